// File: rtl/l1d_bus_xfer.sv
// L1 data cache line mover: a 128-bit line crosses a 32-bit req/ack bus as four
// registered beats. Supports writeback and fill, abort, and a wait watchdog.
module l1d_bus_xfer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   fsm_state,
  input  logic [31:0]  core_addr,
  input  logic [18:0]  victim_tag,
  input  logic [127:0] wr_line,
  output logic         wrt_done,
  output logic         rd_done,
  output logic [127:0] rd_buf,
  output logic         bus_req,
  output logic         bus_we,
  output logic [31:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic         bus_ack,
  input  logic [31:0]  bus_rdata,
  output logic         xfer_err
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] FSM_WRITE_BUS = 2'b01;
  localparam logic [1:0] FSM_READ_BUS  = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_BEAT, RD_BEAT, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         prev_fsm_q, prev_fsm_d;
  logic               abort_q, abort_d;
  logic [31:0]        base_q, base_d;
  logic [127:0]       line_q, line_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [127:0]       rd_buf_q, rd_buf_d;
  logic               wrt_done_q, wrt_done_d;
  logic               rd_done_q, rd_done_d;
  logic               xfer_err_q, xfer_err_d;

  logic [1:0] active_fsm;
  logic       abort_now;
  logic       acked;
  logic       unused_addr_bits;

  // Line bases are 16-byte aligned, so the low address nibble is never used.
  assign unused_addr_bits = ^core_addr[3:0];
  assign active_fsm       = (state_q == WR_BEAT) ? FSM_WRITE_BUS : FSM_READ_BUS;
  assign acked            = bus_req_q & bus_ack;

  always_comb begin
    // NOTE: every _d gets its hold value first; a branch that forgot one would infer a latch.
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    prev_fsm_d  = fsm_state;
    abort_d     = abort_q;
    base_d      = base_q;
    line_d      = line_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_buf_d    = rd_buf_q;
    wrt_done_d  = 1'b0;
    rd_done_d   = 1'b0;
    xfer_err_d  = xfer_err_q;
    abort_now   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fsm_state == FSM_WRITE_BUS && prev_fsm_q != FSM_WRITE_BUS) begin
          state_d     = WR_BEAT;
          beat_d      = 2'd0;
          wait_d      = '0;
          abort_d     = 1'b0;
          xfer_err_d  = 1'b0;
          base_d      = {victim_tag, core_addr[12:4], 4'b0000};
          line_d      = wr_line;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = {victim_tag, core_addr[12:4], 4'b0000};
          bus_wdata_d = wr_line[31:0];
        end else if (fsm_state == FSM_READ_BUS && prev_fsm_q != FSM_READ_BUS) begin
          state_d     = RD_BEAT;
          beat_d      = 2'd0;
          wait_d      = '0;
          abort_d     = 1'b0;
          xfer_err_d  = 1'b0;
          base_d      = {core_addr[31:4], 4'b0000};
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = {core_addr[31:4], 4'b0000};
          bus_wdata_d = '0;
        end
      end

      WR_BEAT, RD_BEAT: begin
        // Once the controller leaves the active state the abort stays pending
        // until the outstanding beat is acknowledged.
        abort_now = abort_q | (fsm_state != active_fsm);
        abort_d   = abort_now;
        if (acked) begin
          wait_d = '0;
          if (state_q == RD_BEAT) rd_buf_d[{beat_q, 5'b0} +: 32] = bus_rdata;
          if (abort_now || beat_q == 2'd3) begin
            state_d     = abort_now ? IDLE : DONE;
            wrt_done_d  = !abort_now && (state_q == WR_BEAT);
            rd_done_d   = !abort_now && (state_q == RD_BEAT);
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = '0;
            bus_wdata_d = '0;
          end else begin
            beat_d      = beat_q + 2'd1;
            bus_addr_d  = base_q + {28'b0, beat_d, 2'b00};
            bus_wdata_d = (state_q == WR_BEAT) ? line_q[{beat_d, 5'b0} +: 32] : '0;
          end
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          // Watchdog: still report completion so the controller cannot hang.
          state_d     = DONE;
          xfer_err_d  = 1'b1;
          wrt_done_d  = (state_q == WR_BEAT);
          rd_done_d   = (state_q == RD_BEAT);
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      prev_fsm_q  <= 2'b00;
      abort_q     <= 1'b0;
      base_q      <= '0;
      line_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_buf_q    <= '0;
      wrt_done_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      xfer_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      prev_fsm_q  <= prev_fsm_d;
      abort_q     <= abort_d;
      base_q      <= base_d;
      line_q      <= line_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_buf_q    <= rd_buf_d;
      wrt_done_q  <= wrt_done_d;
      rd_done_q   <= rd_done_d;
      xfer_err_q  <= xfer_err_d;
    end
  end

  assign wrt_done  = wrt_done_q;
  assign rd_done   = rd_done_q;
  assign rd_buf    = rd_buf_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign xfer_err  = xfer_err_q;

endmodule

// File: tb/tb_l1d_bus_xfer.sv
// Bench for l1d_bus_xfer: a bus slave model plays acks/read data while a
// scoreboard queue holds the beats each transfer is expected to issue.
module tb_l1d_bus_xfer;

  localparam int unsigned TB_MAX_WAIT = 8;

  logic         clk;
  logic         rst_n;
  logic [1:0]   fsm_state;
  logic [31:0]  core_addr;
  logic [18:0]  victim_tag;
  logic [127:0] wr_line;
  logic         wrt_done, rd_done;
  logic [127:0] rd_buf;
  logic         bus_req, bus_we;
  logic [31:0]  bus_addr, bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         xfer_err;

  l1d_bus_xfer #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsm_state  (fsm_state),
    .core_addr  (core_addr),
    .victim_tag (victim_tag),
    .wr_line    (wr_line),
    .wrt_done   (wrt_done),
    .rd_done    (rd_done),
    .rd_buf     (rd_buf),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .xfer_err   (xfer_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic [127:0] fill_line_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Starts a transfer at a negedge, then acts as the bus slave for 'window' cycles.
  // delay = idle negedges before each ack (0 = ack tied high); abort_after = beats
  // acked before fsm_state drops to 00 (-1 = never); done_next = fsm_state to drive
  // on the cycle a done pulse is seen (-1 = leave it).
  task automatic run_xfer(input bit is_wr, input logic [31:0] base, input logic [127:0] line,
                          input int delay, input int abort_after, input int done_next,
                          input int window, output int done_edge, output int n_done,
                          output int n_beats, output int req_cycles);
    int k;
    int wcnt = 0;
    bit new_beat = 1'b1;
    logic [64:0] held = '0;
    beat_t e;
    done_edge = -1; n_done = 0; n_beats = 0; req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      e.addr  = base + 32'(4 * i);
      e.we    = is_wr;
      e.wdata = is_wr ? line[32*i +: 32] : 32'h0;
      e.rdata = is_wr ? 32'hDEAD_BEEF : line[32*i +: 32];
      exp_q.push_back(e);
    end
    bus_ack = (delay == 0);
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    fsm_state = is_wr ? 2'b01 : 2'b10;
    k = cyc + 1;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (abort_after >= 0 && n_beats == abort_after) fsm_state = 2'b00;
      if (wrt_done || rd_done) begin
        n_done++;
        done_edge = cyc + 1 - k;
        n_checks++;
        if ({wrt_done, rd_done} !== (is_wr ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL done_direction: got wrt/rd=%b expected %b", {wrt_done, rd_done},
                   is_wr ? 2'b10 : 2'b01);
        end
        if (done_next >= 0) fsm_state = 2'(done_next);
      end
      if (bus_req) begin
        req_cycles++;
        n_checks++;
        if (new_beat) begin
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: addr=%h we=%b with no beat expected", bus_addr, bus_we);
          end else if ({bus_addr, bus_we, bus_wdata} !== {exp_q[0].addr, exp_q[0].we, exp_q[0].wdata}) begin
            n_fail++;
            $display("FAIL beat: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                     bus_addr, bus_we, bus_wdata, exp_q[0].addr, exp_q[0].we, exp_q[0].wdata);
          end
          held = {bus_addr, bus_we, bus_wdata};
          new_beat = 1'b0;
        end else if ({bus_addr, bus_we, bus_wdata} !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got %h expected %h", {bus_addr, bus_we, bus_wdata}, held);
        end
        if (wcnt >= delay && exp_q.size() > 0) begin
          bus_ack = 1'b1;
          bus_rdata = exp_q[0].rdata;
          void'(exp_q.pop_front());
          n_beats++;
          wcnt = 0;
          new_beat = 1'b1;
        end else begin
          bus_ack = 1'b0;
          bus_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        bus_ack = (delay == 0);
        bus_rdata = 32'hDEAD_BEEF;
      end
    end
    fsm_state = 2'b00;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fsm_state = 2'b00; core_addr = '0; victim_tag = '0; wr_line = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, wrt_done, rd_done, xfer_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/we/wd/rd/err=%b expected 00000",
               {bus_req, bus_we, wrt_done, rd_done, xfer_err});
    end
    n_checks++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0", bus_addr, bus_wdata);
    end
    n_checks++;
    if (rd_buf !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rd_buf: got %h expected 0", rd_buf);
    end
    rst_n = 1'b1;
    bus_ack = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b0 || rd_buf !== 128'h0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got req=%b rd_buf=%h expected 0", bus_req, rd_buf);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_fill();
    int de, nd, nb, rc;
    core_addr = 32'h0000_1234;
    fill_line_exp = 128'h00000044_00000033_00000022_00000011;
    run_xfer(1'b0, 32'h0000_1230, fill_line_exp, 0, -1, -1, 12, de, nd, nb, rc);
    n_checks++;
    if (de !== 5 || nd !== 1) begin
      n_fail++;
      $display("FAIL fill_done: got edge=%0d pulses=%0d expected edge=5 pulses=1", de, nd);
    end
    n_checks++;
    if (nb !== 4 || rc !== 4) begin
      n_fail++;
      $display("FAIL fill_beats: got beats=%0d req_cycles=%0d expected 4 and 4", nb, rc);
    end
    n_checks++;
    if (rd_buf !== fill_line_exp) begin
      n_fail++;
      $display("FAIL fill_rd_buf: got %h expected %h", rd_buf, fill_line_exp);
    end
  endtask

  task automatic test_writeback();
    int de, nd, nb, rc;
    victim_tag = 19'h00001;
    core_addr  = 32'h0000_0050;
    wr_line    = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    run_xfer(1'b1, 32'h0000_2050, wr_line, 0, -1, -1, 12, de, nd, nb, rc);
    n_checks++;
    if (de !== 5 || nd !== 1) begin
      n_fail++;
      $display("FAIL wb_done: got edge=%0d pulses=%0d expected edge=5 pulses=1", de, nd);
    end
    n_checks++;
    if (nb !== 4 || xfer_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_beats: got beats=%0d err=%b expected 4 and 0", nb, xfer_err);
    end
    n_checks++;
    if (rd_buf !== fill_line_exp) begin
      n_fail++;
      $display("FAIL wb_rd_buf_held: got %h expected %h", rd_buf, fill_line_exp);
    end
  endtask

  task automatic test_delayed_ack();
    int de, nd, nb, rc;
    logic [127:0] line;
    line = {$urandom, $urandom, $urandom, $urandom};
    core_addr = 32'hABCD_EF0C;
    run_xfer(1'b0, 32'hABCD_EF00, line, 3, -1, -1, 24, de, nd, nb, rc);
    n_checks++;
    if (de !== 17 || nd !== 1) begin
      n_fail++;
      $display("FAIL delayed_done: got edge=%0d pulses=%0d expected edge=17 pulses=1", de, nd);
    end
    n_checks++;
    if (rd_buf !== line || rc !== 16) begin
      n_fail++;
      $display("FAIL delayed_rd_buf: got %h req_cycles=%0d expected %h and 16", rd_buf, rc, line);
    end
  endtask

  task automatic test_watchdog();
    int de, nd, nb, rc;
    core_addr = 32'h0000_4440;
    run_xfer(1'b0, 32'h0000_4440, 128'h0, 100, -1, -1, 15, de, nd, nb, rc);
    n_checks++;
    if (rc !== int'(TB_MAX_WAIT) || nb !== 0) begin
      n_fail++;
      $display("FAIL wdog_req: got req_cycles=%0d beats=%0d expected %0d and 0", rc, nb, TB_MAX_WAIT);
    end
    n_checks++;
    if (de !== int'(TB_MAX_WAIT) + 1 || nd !== 1) begin
      n_fail++;
      $display("FAIL wdog_done: got edge=%0d pulses=%0d expected edge=%0d pulses=1", de, nd,
               TB_MAX_WAIT + 1);
    end
    n_checks++;
    if (xfer_err !== 1'b1 || exp_q.size() !== 4) begin
      n_fail++;
      $display("FAIL wdog_err: got err=%b left=%0d expected 1 and 4", xfer_err, exp_q.size());
    end
    exp_q.delete();
    victim_tag = 19'h7FFFF;
    core_addr  = 32'h0000_1FF0;
    wr_line    = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(1'b1, 32'hFFFF_FFF0, wr_line, 0, -1, -1, 10, de, nd, nb, rc);
    n_checks++;
    if (xfer_err !== 1'b0 || nd !== 1) begin
      n_fail++;
      $display("FAIL wdog_err_clear: got err=%b pulses=%0d expected 0 and 1", xfer_err, nd);
    end
  endtask

  task automatic test_abort();
    int de, nd, nb, rc;
    victim_tag = 19'h00002;
    core_addr  = 32'h0000_0100;
    wr_line    = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(1'b1, 32'h0000_4100, wr_line, 0, 2, -1, 12, de, nd, nb, rc);
    n_checks++;
    if (nb !== 3 || exp_q.size() !== 1) begin
      n_fail++;
      $display("FAIL abort_beats: got beats=%0d left=%0d expected 3 and 1", nb, exp_q.size());
    end
    n_checks++;
    if (nd !== 0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got pulses=%0d req=%b expected 0 and 0", nd, bus_req);
    end
    exp_q.delete();
  endtask

  task automatic test_start_during_done();
    int de, nd, nb, rc;
    logic [127:0] line;
    line = {$urandom, $urandom, $urandom, $urandom};
    core_addr = 32'h0000_8880;
    run_xfer(1'b0, 32'h0000_8880, line, 0, -1, 1, 14, de, nd, nb, rc);
    n_checks++;
    if (rc !== 4 || nd !== 1 || de !== 5) begin
      n_fail++;
      $display("FAIL start_in_done: got req_cycles=%0d pulses=%0d edge=%0d expected 4 1 5", rc, nd, de);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen = 1'b0;
    int nd = 0;
    int nr = 0;
    core_addr = 32'h0000_5670;
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    fsm_state = 2'b10;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 32'h0000_5678) seen = 1'b1;
    end
    n_checks++;
    if (!seen || rd_buf[63:0] !== {2{32'h0BAD_F00D}}) begin
      n_fail++;
      $display("FAIL rst_mid_reach_beat2: got seen=%b rd_buf_lo=%h expected 1 and %h", seen,
               rd_buf[63:0], {2{32'h0BAD_F00D}});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || rd_buf !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_mid_immediate: got req=%b rd_buf=%h expected 0", bus_req, rd_buf);
    end
    @(negedge clk);
    fsm_state = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_done) nd++;
      if (bus_req) nr++;
    end
    n_checks++;
    if (nd !== 0 || nr !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_after: got done_pulses=%0d req_cycles=%0d expected 0 and 0", nd, nr);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_delayed_ack();
    test_watchdog();
    test_abort();
    test_start_during_done();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
